// File: rtl/sprite_anim_pkg.sv
// Shared types for the sprite walk-cycle animator: facing directions,
// movement codes and the movement-code decoder.
package sprite_anim_pkg;

    typedef enum logic [1:0] {
        DIR_LEFT  = 2'd0,
        DIR_RIGHT = 2'd1,
        DIR_DOWN  = 2'd2,
        DIR_UP    = 2'd3
    } dir_e;

    localparam logic [2:0] MOVE_LEFT  = 3'b000;
    localparam logic [2:0] MOVE_RIGHT = 3'b001;
    localparam logic [2:0] MOVE_DOWN  = 3'b010;
    localparam logic [2:0] MOVE_UP    = 3'b011;
    localparam logic [2:0] MOVE_STOP  = 3'b111;

    typedef struct packed {
        logic valid;
        dir_e dir;
    } move_t;

    // Unlisted codes decode exactly like MOVE_STOP (valid = 0).
    function automatic move_t decode_move(input logic [2:0] code);
        move_t m;
        m.valid = 1'b1;
        m.dir   = DIR_DOWN;
        case (code)
            MOVE_LEFT:  m.dir = DIR_LEFT;
            MOVE_RIGHT: m.dir = DIR_RIGHT;
            MOVE_DOWN:  m.dir = DIR_DOWN;
            MOVE_UP:    m.dir = DIR_UP;
            default:    m.valid = 1'b0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/sprite_anim_tick.sv
// Animation prescaler: counts 0..FRAME_DIV-1 and flags the last count as
// the animation tick.
module sprite_anim_tick #(
    parameter int FRAME_DIV = 100000
) (
    input  logic vga_clk,
    input  logic Reset,
    output logic frame_tick
);
    localparam int CW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

    logic [CW-1:0] cnt;

    assign frame_tick = (cnt == CW'(FRAME_DIV - 1));

    always_ff @(posedge vga_clk or posedge Reset) begin
        if (Reset)
            cnt <= '0;
        else if (frame_tick)
            cnt <= '0;
        else
            cnt <= cnt + CW'(1);
    end

endmodule

// File: rtl/sprite_anim.sv
// Walk-cycle sprite animator producing a concatenated-ROM address and a pixel-valid flag.
// Optional SPRITE_ANIM_VSYNC_LATCH_EN: address uses a frame-start shadow of facing/frame.
module sprite_anim
    import sprite_anim_pkg::*;
#(
    parameter int SPRITE_W  = 21,
    parameter int SPRITE_H  = 30,
    parameter int FRAMES    = 4,
    parameter int FRAME_DIV = 100000,
    parameter int ADDR_W    = $clog2(4 * FRAMES * SPRITE_W * SPRITE_H)
) (
    input  logic                       vga_clk,
    input  logic                       Reset,
    input  logic [9:0]                 DrawX,
    input  logic [9:0]                 DrawY,
    input  logic [9:0]                 PosX,
    input  logic [9:0]                 PosY,
    input  logic [2:0]                 direction,
    output logic [ADDR_W-1:0]          rom_addr,
    output logic                       pix_valid,
    output logic [1:0]                 facing,
    output logic [$clog2(FRAMES)-1:0]  frame_sel,
    output logic                       moving,
    output logic                       frame_tick
);
    localparam int FW      = $clog2(FRAMES);
    localparam int SPR_PIX = SPRITE_W * SPRITE_H;

    sprite_anim_tick #(.FRAME_DIV(FRAME_DIV)) u_tick (
        .vga_clk    (vga_clk),
        .Reset      (Reset),
        .frame_tick (frame_tick)
    );

    dir_e          facing_q, facing_d;
    logic [FW-1:0] frame_q, frame_d;
    logic          moving_q, moving_d;
    move_t         mv;

    // A new direction (or starting from rest) always restarts at frame 0.
    always_comb begin
        mv       = decode_move(direction);
        facing_d = facing_q;
        frame_d  = frame_q;
        moving_d = moving_q;
        if (frame_tick) begin
            if (!mv.valid) begin
                moving_d = 1'b0;
                frame_d  = '0;
            end else if (moving_q && (mv.dir == facing_q)) begin
                frame_d = (frame_q == FW'(FRAMES - 1)) ? '0 : frame_q + FW'(1);
            end else begin
                facing_d = mv.dir;
                frame_d  = '0;
                moving_d = 1'b1;
            end
        end
    end

    always_ff @(posedge vga_clk or posedge Reset) begin
        if (Reset) begin
            facing_q <= DIR_DOWN;
            frame_q  <= '0;
            moving_q <= 1'b0;
        end else begin
            facing_q <= facing_d;
            frame_q  <= frame_d;
            moving_q <= moving_d;
        end
    end

    assign facing    = facing_q;
    assign frame_sel = frame_q;
    assign moving    = moving_q;

    dir_e          addr_facing;
    logic [FW-1:0] addr_frame;

`ifdef SPRITE_ANIM_VSYNC_LATCH_EN
    // Shadow only refreshes at the first pixel of the screen, so a frame never tears.
    always_ff @(posedge vga_clk or posedge Reset) begin
        if (Reset) begin
            addr_facing <= DIR_DOWN;
            addr_frame  <= '0;
        end else if (DrawX == 10'd0 && DrawY == 10'd0) begin
            addr_facing <= facing_q;
            addr_frame  <= frame_q;
        end
    end
`else
    assign addr_facing = facing_q;
    assign addr_frame  = frame_q;
`endif

    // 11-bit edges keep sprites near the right/bottom border from wrapping to 0.
    logic [10:0] x_end, y_end, dx, dy;
    logic        in_spr;
    logic [31:0] sprite_base, pix_off;

    always_comb begin
        x_end       = {1'b0, PosX} + 11'(SPRITE_W);
        y_end       = {1'b0, PosY} + 11'(SPRITE_H);
        dx          = {1'b0, DrawX} - {1'b0, PosX};
        dy          = {1'b0, DrawY} - {1'b0, PosY};
        in_spr      = (DrawX >= PosX) && ({1'b0, DrawX} < x_end) &&
                      (DrawY >= PosY) && ({1'b0, DrawY} < y_end);
        sprite_base = (32'(addr_facing) * 32'(FRAMES) + 32'(addr_frame)) * 32'(SPR_PIX);
        pix_off     = 32'(dy) * 32'(SPRITE_W) + 32'(dx);
        rom_addr    = in_spr ? ADDR_W'(sprite_base + pix_off) : '0;
    end

    always_ff @(posedge vga_clk or posedge Reset) begin
        if (Reset)
            pix_valid <= 1'b0;
        else
            pix_valid <= in_spr;
    end

endmodule

// File: tb/tb_sprite_anim.sv
// Directed bench for sprite_anim with FRAME_DIV=4: tick timing, walk cycle,
// turning, stopping, hit test at the screen edge, address math, async reset.
module tb_sprite_anim;

    localparam int SPRITE_W  = 21;
    localparam int SPRITE_H  = 30;
    localparam int FRAMES    = 4;
    localparam int FRAME_DIV = 4;
    localparam int ADDR_W    = $clog2(4 * FRAMES * SPRITE_W * SPRITE_H);

    logic              vga_clk;
    logic              Reset;
    logic [9:0]        DrawX, DrawY, PosX, PosY;
    logic [2:0]        direction;
    logic [ADDR_W-1:0] rom_addr;
    logic              pix_valid;
    logic [1:0]        facing;
    logic [1:0]        frame_sel;
    logic              moving;
    logic              frame_tick;

    int n_cmp = 0;
    int n_err = 0;

    sprite_anim #(
        .SPRITE_W  (SPRITE_W),
        .SPRITE_H  (SPRITE_H),
        .FRAMES    (FRAMES),
        .FRAME_DIV (FRAME_DIV),
        .ADDR_W    (ADDR_W)
    ) dut (
        .vga_clk    (vga_clk),
        .Reset      (Reset),
        .DrawX      (DrawX),
        .DrawY      (DrawY),
        .PosX       (PosX),
        .PosY       (PosY),
        .direction  (direction),
        .rom_addr   (rom_addr),
        .pix_valid  (pix_valid),
        .facing     (facing),
        .frame_sel  (frame_sel),
        .moving     (moving),
        .frame_tick (frame_tick)
    );

    // clock / reset
    initial vga_clk = 1'b0;
    always #5 vga_clk = ~vga_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge vga_clk);
        #1;
    endtask

    // Advance through the next tick edge; state is updated on return.
    task automatic wait_tick();
        int i;
        i = 0;
        while (!frame_tick && i < 8) begin
            step();
            i++;
        end
        if (!frame_tick) check_eq("tick_timeout", 32'(frame_tick), 1);
        step();
    endtask

    task automatic check_state(input string tag, input logic [1:0] f, input logic [1:0] fr, input logic m);
        check_eq({tag, "_facing"}, 32'(facing), 32'(f));
        check_eq({tag, "_frame"}, 32'(frame_sel), 32'(fr));
        check_eq({tag, "_moving"}, 32'(moving), 32'(m));
    endtask

    initial begin
        int exp_fr[6];
        exp_fr = '{0, 1, 2, 3, 0, 1};

        Reset     = 1'b1;
        direction = 3'b111;
        DrawX     = 10'd0;
        DrawY     = 10'd0;
        PosX      = 10'd300;
        PosY      = 10'd300;
        repeat (2) @(posedge vga_clk);
        #1;
        Reset = 1'b0;

        // reset values and tick cadence (pulses at cycles 3, 7, 11)
        check_state("reset", 2'd2, 2'd0, 1'b0);
        check_eq("reset_pix_valid", 32'(pix_valid), 0);
        check_eq("tick_c0", 32'(frame_tick), 0);
        for (int k = 1; k < 12; k++) begin
            step();
            check_eq($sformatf("tick_c%0d", k), 32'(frame_tick),
                     (k == 3 || k == 7 || k == 11) ? 32'd1 : 32'd0);
        end
        step();
        check_state("idle", 2'd2, 2'd0, 1'b0);

        // walk left for 6 ticks
        direction = 3'b000;
        for (int t = 0; t < 6; t++) begin
            wait_tick();
            check_state($sformatf("walkl_t%0d", t), 2'd0, 2'(exp_fr[t]), 1'b1);
        end

        // turn up between ticks: ignored until the tick
        wait_tick();
        check_state("walkl_f2", 2'd0, 2'd2, 1'b1);
        direction = 3'b011;
        step();
        check_state("turn_pending", 2'd0, 2'd2, 1'b1);
        wait_tick();
        check_state("turn_up", 2'd3, 2'd0, 1'b1);

        // walk right then stop with 111 and with invalid 101
        direction = 3'b001;
        wait_tick();
        check_state("walkr_t0", 2'd1, 2'd0, 1'b1);
        wait_tick();
        check_state("walkr_t1", 2'd1, 2'd1, 1'b1);
        direction = 3'b111;
        wait_tick();
        check_state("stop_111", 2'd1, 2'd0, 1'b0);
        direction = 3'b001;
        wait_tick();
        check_state("rewalk_r", 2'd1, 2'd0, 1'b1);
        direction = 3'b101;
        wait_tick();
        check_state("stop_101", 2'd1, 2'd0, 1'b0);

        // idle facing left, frame 0
        direction = 3'b000;
        wait_tick();
        direction = 3'b111;
        wait_tick();
        check_state("idle_left", 2'd0, 2'd0, 1'b0);

        // right-edge sweep
        PosX  = 10'd630;
        PosY  = 10'd0;
        DrawX = 10'd0;
        DrawY = 10'd0;
        step();
        for (int x = 629; x <= 639; x++) begin
            DrawX = 10'(x);
            #1;
            check_eq($sformatf("edge_addr_x%0d", x), 32'(rom_addr),
                     (x >= 630) ? 32'(x - 630) : 32'd0);
            step();
            check_eq($sformatf("edge_pv_x%0d", x), 32'(pix_valid), (x >= 630) ? 32'd1 : 32'd0);
        end
        DrawX = 10'd0;
        DrawY = 10'd1;
        #1;
        check_eq("nextline_addr", 32'(rom_addr), 0);
        step();
        check_eq("nextline_pv", 32'(pix_valid), 0);

        // sprite straddling 1023: 11-bit sums keep the hit
        PosX  = 10'd1015;
        DrawX = 10'd1020;
        DrawY = 10'd3;
        #1;
        check_eq("wide_addr", 32'(rom_addr), 32'd68);
        step();
        check_eq("wide_pv", 32'(pix_valid), 1);
        DrawX = 10'd5;
        #1;
        check_eq("wide_nowrap_addr", 32'(rom_addr), 0);
        step();
        check_eq("wide_nowrap_pv", 32'(pix_valid), 0);

        // facing up, frame 1, address math
        PosX      = 10'd100;
        PosY      = 10'd100;
        DrawX     = 10'd101;
        DrawY     = 10'd102;
        direction = 3'b011;
        wait_tick();
        check_state("up_t0", 2'd3, 2'd0, 1'b1);
        DrawX = 10'd0;
        DrawY = 10'd0;
        step();
        DrawX = 10'd101;
        DrawY = 10'd102;
        wait_tick();
        check_state("up_t1", 2'd3, 2'd1, 1'b1);
`ifdef SPRITE_ANIM_VSYNC_LATCH_EN
        check_eq("addr_midscreen", 32'(rom_addr), 32'd7603);
`else
        check_eq("addr_midscreen", 32'(rom_addr), 32'd8233);
`endif
        DrawX = 10'd0;
        DrawY = 10'd0;
        step();
        DrawX = 10'd101;
        DrawY = 10'd102;
        #1;
        check_eq("addr_newscreen", 32'(rom_addr), 32'd8233);
        step();
        check_eq("addr_pv", 32'(pix_valid), 1);

        // asynchronous reset mid-walk
        #1;
        Reset = 1'b1;
        #1;
        check_state("async_rst", 2'd2, 2'd0, 1'b0);
        check_eq("async_rst_pv", 32'(pix_valid), 0);
        check_eq("async_rst_tick", 32'(frame_tick), 0);
        #2;
        Reset = 1'b0;
        step();
        step();
        check_eq("rst_tick_c2", 32'(frame_tick), 0);
        step();
        check_eq("rst_tick_c3", 32'(frame_tick), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sprite_anim.md
# sprite_anim

Parametrised walk-cycle animator for character sprites (guard, player, NPCs) in the VGA pipeline. Samples a 3-bit movement code once per animation tick and advances a per-direction frame counter. Remembers the last facing direction when the character stops. Generates a single address into a concatenated sprite ROM (all directions × all frames) plus an in-sprite flag aligned to the ROM's one-cycle read latency. Sits between the character movement controller and the colour mapper.

## Interface
Parameters:
- `SPRITE_W`, 21, sprite width in pixels
- `SPRITE_H`, 30, sprite height in pixels
- `FRAMES`, 4, walk frames per direction (≥2)
- `FRAME_DIV`, 100000, `vga_clk` cycles per animation tick (≥2)
- `ADDR_W`, `$clog2(4*FRAMES*SPRITE_W*SPRITE_H)`, ROM address width

Ports:
- `vga_clk`  in  1  pixel clock; the only clock
- `Reset`  in  1  asynchronous, active-high reset
- `DrawX`, `DrawY`  in  10 each  current beam pixel
- `PosX`, `PosY`  in  10 each  sprite top-left pixel
- `direction`  in  3  000 left, 001 right, 010 down, 011 up, 111 stop; other codes are treated as stop
- `rom_addr`  out  ADDR_W  combinational address to the synchronous sprite ROM
- `pix_valid`  out  1  registered; high when the ROM word currently returned belongs to the sprite
- `facing`  out  2  registered direction index (0 L, 1 R, 2 D, 3 U)
- `frame_sel`  out  `$clog2(FRAMES)`  registered current frame
- `moving`  out  1  registered walking flag
- `frame_tick`  out  1  one-cycle pulse at each animation tick

## Operation
- Prescaler `cnt` counts 0..FRAME_DIV-1 and wraps to 0. `frame_tick` = (`cnt` == FRAME_DIV-1).
- Animation state {`facing`, `frame_sel`, `moving`} updates only on the edge where `frame_tick` = 1:
  - Valid direction d with `moving`=1 and d=`facing`: `frame_sel` ← (`frame_sel`==FRAMES-1) ? 0 : `frame_sel`+1.
  - Valid direction d otherwise (starting from rest, or turning): `facing` ← d, `frame_sel` ← 0, `moving` ← 1.
  - Stop or invalid code: `moving` ← 0, `frame_sel` ← 0, `facing` held. Idle pose is frame 0 of the last facing direction.
- Direction changes between ticks are ignored. Only the value present at the tick edge counts.
- Hit test: `in_spr` = DrawX ≥ PosX, DrawX < PosX+SPRITE_W, DrawY ≥ PosY, and DrawY < PosY+SPRITE_H.
  - All sums are computed in 11 bits, so a sprite near X=639 or Y=479 never wraps to column or row 0.
- `rom_addr` = ((`facing`·FRAMES + `frame_sel`)·SPRITE_W·SPRITE_H) + (DrawY−PosY)·SPRITE_W + (DrawX−PosX) when `in_spr`; 0 otherwise. Truncated to ADDR_W.
- `pix_valid` ← `in_spr` registered once, matching the ROM's registered output.

## Timing
- Reset values: `cnt`=0, `facing`=2 (down), `frame_sel`=0, `moving`=0, `pix_valid`=0, `frame_tick`=0.
- `frame_tick` first asserts FRAME_DIV-1 cycles after reset release, then every FRAME_DIV cycles.
- State latency: `direction` sampled at the tick edge; new `facing`/`frame_sel` are visible the cycle after.
- `rom_addr` is a zero-cycle path from DrawX/DrawY and registered state. `pix_valid` and ROM data arrive one cycle later.
- Reset asserted mid-walk: all state returns to its reset value immediately (asynchronously). The prescaler restarts from 0.
- Simultaneous tick and turn: the turn wins, and the frame restarts at 0 in the new direction.

## Configuration
- `SPRITE_ANIM_VSYNC_LATCH_EN` defined: `facing`/`frame_sel` feed `rom_addr` through a shadow register.
  - The shadow loads only on the cycle DrawX==0 && DrawY==0, so the sprite frame never changes mid-scan (no tearing).
  - The `facing`/`frame_sel`/`moving` ports still show live state.
- Macro undefined: `rom_addr` uses live state directly, with no shadow registers.

## Structure
- Package `sprite_anim_pkg`:
  - enum `dir_e` {DIR_LEFT=0, DIR_RIGHT=1, DIR_DOWN=2, DIR_UP=3}
  - localparams for the 3-bit movement codes, including `MOVE_STOP`=3'b111
  - function mapping a movement code to valid/`dir_e`
- Sub-module `sprite_anim_tick`: parametrised FRAME_DIV prescaler with `vga_clk`/`Reset`, output `frame_tick`.

## Test plan
- Reset, FRAME_DIV=4, `direction`=111 → `facing`=2, `frame_sel`=0, `moving`=0; `frame_tick` pulses at cycles 3, 7, 11.
- Hold 000 for 6 ticks → `facing`=0, `frame_sel` sequence 0,1,2,3,0,1 after successive ticks; `moving`=1.
- Walking left at frame 2, switch to 011 between ticks → no change until the tick; then `facing`=3, `frame_sel`=0.
- Walking right, drive 111 (then 101) → `moving`=0, `frame_sel`=0, `facing` stays 1.
- PosX=630, PosY=0, facing=0, frame 0, sweep DrawX 629..639 on DrawY=0 → `pix_valid` high one cycle after DrawX 630..639, `rom_addr` 0..9; DrawX=0 on the next line gives no hit.
- Facing up, frame 1, PosX=PosY=100, DrawX=101, DrawY=102 → `rom_addr` = 13·630+43 = 8233. With `SPRITE_ANIM_VSYNC_LATCH_EN`, a tick mid-screen leaves `rom_addr` on the old frame until DrawX=DrawY=0.
